// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data RAM between the CPU load/store
//               path and a loader/debug port. One RAM access per cycle.
//               The CPU is stalled combinationally when it is not granted.
//               Locked loader bursts are bounded by MAX_HOLD cycles in which
//               the CPU is waiting, so the CPU cannot starve.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU load/store path
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    // Loader / debug port
    input  logic                  ldr_req,
    input  logic                  ldr_lock,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_gnt,
    output logic                  ldr_rvalid,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    // RAM port
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Hold counter must be able to represent MAX_HOLD itself.
    localparam int                  c_HCNT_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [c_HCNT_W-1:0] c_HOLD_LIMIT = c_HCNT_W'(MAX_HOLD);
    localparam logic [c_HCNT_W-1:0] c_HCNT_ONE   = c_HCNT_W'(1);
    localparam logic [c_HCNT_W-1:0] c_HCNT_ZERO  = '0;

    // Encoding of the "last granted requester" state.
    localparam logic [0:0] c_LAST_CPU = 1'b0;
    localparam logic [0:0] c_LAST_LDR = 1'b1;

    // ------------------------------------------------------------------
    // Registered arbitration state
    // ------------------------------------------------------------------
    logic [0:0]            r_last;
    logic                  r_locked;
    logic [c_HCNT_W-1:0]   r_hcnt;
    logic                  r_ldr_rvalid;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic                  w_run;        // high when out of reset
    logic                  w_ldr_locked; // loader still asking for the burst
    logic                  w_force_cpu;  // hold budget exhausted, CPU takes a slot
    logic                  w_hold_ldr;   // locked loader keeps the RAM
    logic [0:0]            w_last_eff;   // last requester as seen by the unlocked rule
    logic                  w_cpu_gnt;
    logic                  w_ldr_gnt;
    logic [0:0]            w_last_nxt;
    logic                  w_locked_nxt;
    logic [c_HCNT_W-1:0]   w_hcnt_nxt;
    logic                  w_ldr_rd;

    // Reset is active-low; while it is asserted no access may be issued.
    assign w_run        = reset;
    assign w_ldr_locked = ldr_req & ldr_lock;
    assign w_force_cpu  = r_locked & w_ldr_locked & cpu_req & (r_hcnt == c_HOLD_LIMIT);
    assign w_hold_ldr   = r_locked & w_ldr_locked & ~w_force_cpu;

    // A dropped lock falls back to round-robin as if the loader went last.
    assign w_last_eff   = r_locked ? c_LAST_LDR : r_last;

    // Grant decision: forced CPU slot, then locked loader, then round-robin.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (!w_run) begin
            w_cpu_gnt = 1'b0;
            w_ldr_gnt = 1'b0;
        end else if (w_force_cpu) begin
            w_cpu_gnt = 1'b1;
        end else if (w_hold_ldr) begin
            w_ldr_gnt = 1'b1;
        end else if (cpu_req && ldr_req) begin
            if (w_last_eff == c_LAST_LDR) begin
                w_cpu_gnt = 1'b1;
            end else begin
                w_ldr_gnt = 1'b1;
            end
        end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
        end else if (ldr_req) begin
            w_ldr_gnt = 1'b1;
        end
    end

    // Next arbitration state derived from this cycle's grant.
    always_comb begin
        w_last_nxt   = w_last_eff;
        w_locked_nxt = 1'b0;
        w_hcnt_nxt   = c_HCNT_ZERO;
        if (w_cpu_gnt) begin
            // Any CPU grant (forced or normal) ends a burst.
            w_last_nxt = c_LAST_CPU;
        end else if (w_ldr_gnt) begin
            w_last_nxt = c_LAST_LDR;
            if (w_hold_ldr) begin
                // Only cycles in which the CPU is kept waiting use up budget.
                w_locked_nxt = 1'b1;
                w_hcnt_nxt   = r_hcnt + c_HCNT_W'(cpu_req);
            end else if (ldr_lock) begin
                // Entering a burst counts as the first held grant.
                w_locked_nxt = 1'b1;
                w_hcnt_nxt   = c_HCNT_ONE;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last   <= c_LAST_LDR;
            r_locked <= 1'b0;
            r_hcnt   <= c_HCNT_ZERO;
        end else begin
            r_last   <= w_last_nxt;
            r_locked <= w_locked_nxt;
            r_hcnt   <= w_hcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // RAM drive: follow the granted requester, idle bus is all zeros.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ldr_gnt) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    assign mem_write = (w_cpu_gnt & cpu_we) | (w_ldr_gnt & ldr_we);
    assign mem_read  = (w_cpu_gnt & ~cpu_we) | (w_ldr_gnt & ~ldr_we);

    assign cpu_stall = cpu_req & ~w_cpu_gnt;
    assign cpu_rdata = mem_rdata;
    assign ldr_gnt   = w_ldr_gnt;

    // ------------------------------------------------------------------
    // Loader read return path: one-cycle registered data and valid.
    // ------------------------------------------------------------------
    assign w_ldr_rd = w_ldr_gnt & ~ldr_we;

    // Capture RAM data at the end of a loader read; valid for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ldr_rvalid <= 1'b0;
            r_ldr_rdata  <= '0;
        end else begin
            r_ldr_rvalid <= w_ldr_rd;
            if (w_ldr_rd) begin
                r_ldr_rdata <= mem_rdata;
            end
        end
    end

    assign ldr_rvalid = r_ldr_rvalid;
    assign ldr_rdata  = r_ldr_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data RAM of the single-cycle MIPS core. It shares the RAM between the CPU load/store path and a loader/debug port that fills or inspects data memory while the core runs. It issues at most one RAM access per cycle and stalls the CPU combinationally when the CPU is not granted. It supports locked loader bursts with a bounded hold time so the CPU cannot starve.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and of the RAM.
- DATA_WIDTH, 32, data width.
- MAX_HOLD, 16, maximum consecutive loader grants under lock while the CPU is waiting. Legal values are 1 and above.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request: MemRead or MemWrite of the core.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address (ALU result).
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_stall  out  1  freeze PC and register write this cycle.
- cpu_rdata  out  DATA_WIDTH  load data, combinational, valid in the grant cycle.
- ldr_req  in  1  loader access request.
- ldr_lock  in  1  loader requests burst ownership.
- ldr_we  in  1  1 = write, 0 = read.
- ldr_addr  in  ADDR_WIDTH  loader address.
- ldr_wdata  in  DATA_WIDTH  loader write data.
- ldr_gnt  out  1  loader access issued this cycle.
- ldr_rvalid  out  1  registered read data valid.
- ldr_rdata  out  DATA_WIDTH  registered read data.
- mem_write  out  1  RAM write enable.
- mem_read  out  1  RAM read enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM asynchronous read data.

## Operation
- **Requester rule:** each requester holds req, we, addr and wdata stable until it is granted. The CPU does this because cpu_stall freezes the PC.
- **Grant decision:** combinational from the requests and the registered state. At most one of cpu_gnt (internal) and ldr_gnt is 1. cpu_stall = cpu_req & ~cpu_gnt.
- **RAM drive:**
  - mem_read = gnt & ~we and mem_write = gnt & we, using the granted requester's signals.
  - mem_addr and mem_wdata follow the granted requester, and are 0 when nothing is granted.
  - cpu_rdata = mem_rdata, pass-through.
- **State register:** last (LAST_CPU / LAST_LDR), locked (0/1), hold counter hcnt of width clog2(MAX_HOLD+1).
- **Unlocked (locked=0):**
  - Single requester is granted.
  - When both request, the requester not equal to last is granted.
  - last updates to the granted requester.
  - A loader grant with ldr_lock=1 sets locked=1 and hcnt=1.
- **Locked (locked=1):**
  - If ldr_req=1 and ldr_lock=1, the loader is granted. If cpu_req=1 in that cycle, hcnt increments.
  - When hcnt==MAX_HOLD and cpu_req=1, the loader is denied and the CPU is granted for that cycle. Then locked=0, hcnt=0, last=LAST_CPU.
  - If ldr_lock=0 or ldr_req=0, locked clears in that cycle and the grant follows the unlocked rule with last=LAST_LDR.
  - hcnt does not count cycles in which cpu_req=0. A lone loader burst is unbounded.
- **After a forced CPU slot:** a still-locked loader is granted next (last=LAST_CPU), which re-enters locked with hcnt=1.
- **Loader reads:** ldr_rdata captures mem_rdata at the clock edge ending a loader read-grant cycle. ldr_rvalid=1 for exactly the following cycle, otherwise 0. ldr_rdata holds its value until the next loader read.
- **Writes:** the RAM commits a write on the clock edge ending its grant cycle. Same-address CPU and loader requests are serialised by arbitration; no merging.

## Timing
- **Reset (reset=0):** last=LAST_LDR (CPU wins the first contention), locked=0, hcnt=0, ldr_rvalid=0, ldr_rdata=0.
- **During reset:** all grants are forced to 0, so mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0, ldr_gnt=0. cpu_stall = cpu_req.
- **Reset asserted mid-burst:** the state clears immediately. Any pending ldr_rvalid is dropped.
- **CPU access latency:** 0 cycles when granted; load data is in the same cycle. Each denied cycle adds one stall cycle.
- **Loader latency:** grant in cycle N, write committed at the end of N, read data has ldr_rvalid in N+1.
- **Worst-case CPU wait:**
  - Unlocked: 1 cycle.
  - Locked: MAX_HOLD cycles.

## Test plan
- **Reset:** hold reset=0 with cpu_req=ldr_req=1.
  - mem_read = mem_write = 0, ldr_gnt=0, cpu_stall=1.
  - After release, the first contention grants the CPU.
- **CPU load:** cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0xDEADBEEF → in the same cycle, mem_read=1, mem_addr=0x10, cpu_rdata=0xDEADBEEF, cpu_stall=0.
- **Round-robin:** both requesters request continuously, unlocked → grants alternate CPU, LDR, CPU, LDR. cpu_stall=1 exactly on the loader cycles.
- **Locked burst with MAX_HOLD=4:**
  - Setup: ldr_lock=1 and cpu_req=1 from cycle 0.
  - Required grant sequence: C, L, L, L, L, C, L, L, L, L, C, …
  - The CPU is never stalled for more than 4 consecutive cycles.
- **Loader read:** ldr_we=0, ldr_addr=0x20, mem_rdata=0x12345678 in grant cycle N → ldr_rvalid=1 and ldr_rdata=0x12345678 in N+1 only, ldr_rvalid=0 in N+2.
- **Reset mid-lock:** assert reset in the 3rd locked cycle, then release with both requesting → locked=0, and the CPU is granted first after release.
